// File: rtl/seq_gen_display.sv
// seq_gen_display: builds the random digit sequence for a level and
// plays it on the display one digit at a time.
module seq_gen_display #(
    parameter int          MAX_DIGITS  = 7,
    parameter int          SHOW_CYCLES = 50000000,
    parameter int          GAP_CYCLES  = 12500000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    auth_bit,
    input  logic                    logout,
    input  logic                    rng_button,
    input  logic [3:0]              level_num,
    output logic [4*MAX_DIGITS-1:0] store_reg,
    output logic [3:0]              disp_digit,
    output logic                    disp_valid,
    output logic                    play_done,
    output logic                    busy
);

    localparam int DMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(DMAX + 1);
    localparam int IW   = $clog2(MAX_DIGITS + 1);
    localparam int SW   = 4 * MAX_DIGITS;

    typedef enum logic [2:0] {
        IDLE, READY, GEN, SHOW, GAP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q;
    logic          rng_prev_q;
    logic [SW-1:0] store_q, store_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] len_q, len_d;
    logic [CW-1:0] dwell_q, dwell_d;

    logic          press;
    logic          lvl_ok;
    logic          accept;
    logic          last_idx;
    logic [3:0]    digit;
    logic [IW-1:0] sel;
    logic [3:0]    nib;

    assign press    = rng_prev_q & ~rng_button;
    assign lvl_ok   = (level_num != 4'd0) && (level_num <= 4'd5);
    assign accept   = (state_q == READY) && press && lvl_ok;
    assign last_idx = (idx_q == len_q - IW'(1));
    assign digit    = (lfsr_q[3:0] % 4'd9) + 4'd1;
    assign sel      = len_q - IW'(1) - idx_q;
    assign nib      = 4'(store_q >> {sel, 2'b00});

    // LFSR free-runs in every state; button edge detector history
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            lfsr_q     <= LFSR_SEED;
            rng_prev_q <= 1'b1;
        end else begin
            lfsr_q     <= {lfsr_q[14:0],
                           lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            rng_prev_q <= rng_button;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            store_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dwell_q <= dwell_d;
        end
    end

    // Next state; logout overrides everything
    always_comb begin
        state_d = state_q;
        if (logout) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (auth_bit) state_d = READY;
                READY: if (accept) state_d = GEN;
                GEN:   if (last_idx) state_d = SHOW;
                SHOW:  if (dwell_q == '0) state_d = last_idx ? DONE : GAP;
                GAP:   if (dwell_q == '0) state_d = SHOW;
                DONE:  state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    // Sequence store, digit index and dwell counter updates
    always_comb begin
        store_d = store_q;
        idx_d   = idx_q;
        len_d   = len_q;
        dwell_d = dwell_q;
        if (logout) begin
            store_d = '0;
            idx_d   = '0;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                READY: begin
                    if (accept) begin
                        store_d = '0;
                        idx_d   = '0;
                        len_d   = IW'(level_num + 4'd2);
                    end
                end
                GEN: begin
                    store_d = {store_q[SW-5:0], digit};
                    if (last_idx) begin
                        idx_d   = '0;
                        dwell_d = CW'(SHOW_CYCLES - 1);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                SHOW: begin
                    if (dwell_q == '0) begin
                        if (!last_idx) dwell_d = CW'(GAP_CYCLES - 1);
                    end else begin
                        dwell_d = dwell_q - CW'(1);
                    end
                end
                GAP: begin
                    if (dwell_q == '0) begin
                        idx_d   = idx_q + IW'(1);
                        dwell_d = CW'(SHOW_CYCLES - 1);
                    end else begin
                        dwell_d = dwell_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        store_reg  = store_q;
        disp_valid = (state_q == SHOW);
        disp_digit = (state_q == SHOW) ? nib : 4'd0;
        busy       = (state_q == GEN) || (state_q == SHOW) || (state_q == GAP);
        play_done  = (state_q == DONE);
    end

endmodule

// File: tb/tb_seq_gen_display.sv
// tb_seq_gen_display: directed vectors and hand sequences for the
// digit sequence generator with short show/gap times.
module tb_seq_gen_display;

    localparam int          SHOW = 4;
    localparam int          GAP  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        auth_bit = 1'b0;
    logic        logout = 1'b0;
    logic        rng_button = 1'b1;
    logic [3:0]  level_num = 4'd1;
    logic [27:0] store_reg;
    logic [3:0]  disp_digit;
    logic        disp_valid;
    logic        play_done;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    typedef struct {
        logic [3:0] level;
        logic       accept;
        logic       noisy;
        int         exp_len;
    } vec_t;

    vec_t tbl[6];

    seq_gen_display #(
        .MAX_DIGITS (7),
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES (GAP),
        .LFSR_SEED  (SEED)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .auth_bit  (auth_bit),
        .logout    (logout),
        .rng_button(rng_button),
        .level_num (level_num),
        .store_reg (store_reg),
        .disp_digit(disp_digit),
        .disp_valid(disp_valid),
        .play_done (play_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Sequence expected when the accepting edge is posedge number p
    function automatic logic [27:0] exp_store(input int p, input int l);
        logic [15:0] s;
        logic [27:0] r;
        logic [3:0]  d;
        s = SEED;
        r = '0;
        for (int i = 0; i < p; i++) s = step(s);
        for (int k = 0; k < l; k++) begin
            d = 4'(s[3:0] % 4'd9) + 4'd1;
            r = {r[23:0], d};
            s = step(s);
        end
        return r;
    endfunction

    // Expected outputs o cycles after the accepting edge
    task automatic check_cycle(input int o, input int l, input logic [27:0] e, inout int pd);
        int r, idx, ph;
        logic [3:0] ed;
        if (o < l) begin
            chk("gen_busy", busy, 1);
            chk("gen_valid", disp_valid, 0);
            chk("gen_done", play_done, 0);
            chk("gen_store", store_reg, e >> (4 * (l - o)));
        end else begin
            r   = o - l;
            idx = r / (SHOW + GAP);
            ph  = r % (SHOW + GAP);
            chk("store_hold", store_reg, e);
            if (idx < l && ph < SHOW) begin
                ed = 4'(e >> (4 * (l - 1 - idx)));
                chk("show_valid", disp_valid, 1);
                chk("show_digit", disp_digit, ed);
                chk("show_busy", busy, 1);
                chk("show_done", play_done, 0);
            end else if (idx < l - 1) begin
                chk("gap_valid", disp_valid, 0);
                chk("gap_digit", disp_digit, 0);
                chk("gap_busy", busy, 1);
                chk("gap_done", play_done, 0);
            end else if (idx == l - 1 && ph == SHOW) begin
                chk("done_pulse", play_done, 1);
                chk("done_busy", busy, 0);
                chk("done_valid", disp_valid, 0);
            end else begin
                chk("ready_done", play_done, 0);
                chk("ready_busy", busy, 0);
                chk("ready_valid", disp_valid, 0);
            end
        end
        if (play_done) pd++;
    endtask

    task automatic reset_auth();
        rst        = 1'b0;
        rng_button = 1'b1;
        logout     = 1'b0;
        auth_bit   = 1'b0;
        level_num  = 4'd1;
        @(negedge clock);
        chk("rst_store", store_reg, 0);
        chk("rst_digit", disp_digit, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_done", play_done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        rst      = 1'b1;
        auth_bit = 1'b1;
        @(negedge clock);
    endtask

    task automatic start_round(input logic [3:0] lvl, output int p);
        @(negedge clock);
        level_num  = lvl;
        rng_button = 1'b0;
        p          = cyc + 1;
    endtask

    task automatic play_round(input logic [3:0] lvl, input bit noisy,
                              output logic [27:0] fs);
        int p, l, last, pd;
        logic [27:0] e;
        pd   = 0;
        l    = int'(lvl) + 2;
        start_round(lvl, p);
        e    = exp_store(p, l);
        last = l + (SHOW + GAP) * (l - 1) + SHOW + 1;
        for (int o = 0; o <= last; o++) begin
            @(negedge clock);
            check_cycle(o, l, e, pd);
            if (o == 0) level_num = 4'd0;
            if (!noisy) rng_button = 1'b1;
            else rng_button = (o >= l + 10) ? 1'b0 : o[0];
        end
        chk("play_done_count", pd, 1);
        for (int i = 0; i < l; i++) chk("nibble_nonzero", store_reg[4*i +: 4] != 4'd0, 1);
        fs = store_reg;
        if (noisy) begin
            repeat (3) begin
                @(negedge clock);
                chk("held_no_retrigger", busy, 0);
                chk("held_store", store_reg, e);
            end
            rng_button = 1'b1;
        end
    endtask

    initial begin
        int p, l, pd;
        logic [27:0] e, s1, fs, last_store;

        tbl[0] = '{level: 4'd0,  accept: 1'b0, noisy: 1'b0, exp_len: 0};
        tbl[1] = '{level: 4'd6,  accept: 1'b0, noisy: 1'b0, exp_len: 0};
        tbl[2] = '{level: 4'd1,  accept: 1'b1, noisy: 1'b0, exp_len: 3};
        tbl[3] = '{level: 4'd5,  accept: 1'b1, noisy: 1'b0, exp_len: 7};
        tbl[4] = '{level: 4'd4,  accept: 1'b1, noisy: 1'b1, exp_len: 6};
        tbl[5] = '{level: 4'd15, accept: 1'b0, noisy: 1'b0, exp_len: 0};

        // async reset in the middle of SHOW, then the same digits again
        reset_auth();
        pd = 0;
        l  = 5;
        start_round(4'd3, p);
        e = exp_store(p, l);
        for (int o = 0; o <= l + 1; o++) begin
            @(negedge clock);
            check_cycle(o, l, e, pd);
            if (o == 0) rng_button = 1'b1;
        end
        s1 = store_reg;
        @(posedge clock);
        #2 rst = 1'b0;
        #1;
        chk("async_store", store_reg, 0);
        chk("async_digit", disp_digit, 0);
        chk("async_valid", disp_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_done", play_done, 0);
        reset_auth();
        play_round(4'd3, 1'b0, fs);
        chk("reseed_repeat", fs, s1);

        // table of levels: invalid ones must be ignored
        reset_auth();
        last_store = '0;
        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].accept) begin
                start_round(tbl[i].level, p);
                repeat (2) begin
                    @(negedge clock);
                    chk("invalid_busy", busy, 0);
                    chk("invalid_store", store_reg, last_store);
                end
                rng_button = 1'b1;
            end else begin
                play_round(tbl[i].level, tbl[i].noisy, fs);
                chk("pad_zero", fs >> (4 * tbl[i].exp_len), 0);
                last_store = fs;
            end
        end

        // logout during the gap after the second digit
        pd = 0;
        l  = 4;
        start_round(4'd2, p);
        e = exp_store(p, l);
        for (int o = 0; o <= l + SHOW + GAP + SHOW; o++) begin
            @(negedge clock);
            check_cycle(o, l, e, pd);
            if (o == 0) rng_button = 1'b1;
        end
        logout   = 1'b1;
        auth_bit = 1'b0;
        @(negedge clock);
        chk("logout_store", store_reg, 0);
        chk("logout_digit", disp_digit, 0);
        chk("logout_valid", disp_valid, 0);
        chk("logout_busy", busy, 0);
        chk("logout_done", play_done, 0);
        logout     = 1'b0;
        level_num  = 4'd3;
        rng_button = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("noauth_busy", busy, 0);
            chk("noauth_store", store_reg, 0);
        end
        rng_button = 1'b1;
        @(negedge clock);
        auth_bit = 1'b1;
        @(negedge clock);
        play_round(4'd1, 1'b0, fs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
